// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage divider sequencing controller.
package div_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // Divide-by-zero answer: remainder is the dividend, quotient all ones.
  function automatic logic [63:0] div_zero_result(input logic [31:0] dividend);
    return {dividend, DIV_ZERO_LO};
  endfunction

endpackage

// File: rtl/div_seq_ctrl_watchdog.sv
// BUSY-cycle counter for the divider sequencer; flags when the timeout is reached.
module div_watchdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter reads 0 in the first BUSY cycle, so TIMEOUT-1 marks the last allowed one.
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequences DIV/DIVU from EX through the iterative divider and holds the result for EX.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        pipe_hold,
  output logic        stall_o,
  output logic        result_valid,
  output logic [63:0] result_o,
  output logic        timeout_o,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result
);

  div_state_e  state_q, state_d;
  logic        start_q, start_d;
  logic        annul_q, annul_d;
  logic        signed_q, signed_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] result_q, result_d;
  logic        rvalid_q, rvalid_d;
  logic        timeout_q, timeout_d;
  logic        wd_expired;

  div_watchdog #(
    .TIMEOUT (DIV_TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ST_BUSY),
    .en      (state_q == ST_BUSY),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    annul_d   = 1'b0;
    signed_d  = signed_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          if (req_b != '0) begin
            signed_d = req_signed;
            opa_d    = req_a;
            opb_d    = req_b;
            start_d  = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            result_d = div_zero_result(req_a);
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        // Flush beats a same-cycle div_ready; div_ready beats the watchdog.
        if (flush) begin
          annul_d = 1'b1;
          state_d = ST_IDLE;
        end else if (div_ready) begin
          result_d = div_result;
          state_d  = ST_DONE;
        end else if (wd_expired) begin
          annul_d   = 1'b1;
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || !pipe_hold) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rvalid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      annul_q   <= 1'b0;
      signed_q  <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      rvalid_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      annul_q   <= annul_d;
      signed_q  <= signed_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      rvalid_q  <= rvalid_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_o      = ((state_q == ST_IDLE) && req_valid && !flush) || (state_q == ST_BUSY);
  assign result_valid = rvalid_q;
  assign result_o     = result_q;
  assign timeout_o    = timeout_q;
  assign div_start    = start_q;
  assign div_annul    = annul_q;
  assign div_signed   = signed_q;
  assign div_opa      = opa_q;
  assign div_opb      = opb_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized scoreboard bench for div_seq_ctrl with a stub iterative divider.
module tb_div_seq_ctrl;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_signed = 1'b0, flush = 1'b0, pipe_hold = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        stall_o, result_valid, timeout_o, div_start, div_signed, div_annul;
  logic [63:0] result_o;
  logic [31:0] div_opa, div_opb;
  logic        stub_ready = 1'b0, force_ready = 1'b0, junk_ready = 1'b0;
  logic [63:0] stub_res = '0, junk_res = '0;
  logic        div_ready;
  logic [63:0] div_result;

  assign div_ready  = stub_ready | force_ready | junk_ready;
  assign div_result = stub_ready ? stub_res : junk_res;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          stub_lat = 1;

  always #5 clk = ~clk;

  div_seq_ctrl #(.DIV_TIMEOUT(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .flush(flush), .pipe_hold(pipe_hold),
    .stall_o(stall_o), .result_valid(result_valid), .result_o(result_o),
    .timeout_o(timeout_o), .div_start(div_start), .div_signed(div_signed),
    .div_opa(div_opa), .div_opb(div_opb), .div_annul(div_annul),
    .div_ready(div_ready), .div_result(div_result)
  );

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    int          sa, sb;
    int unsigned ua, ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    ua = a;
    ub = b;
    return {ua % ub, ua / ub};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub divider: answers lat cycles after div_start from the operands it was handed.
  initial begin : stub
    int          cnt;
    bit          active;
    logic [31:0] ca, cb;
    logic        cs;
    active = 0;
    cnt = 0;
    ca = '0;
    cb = '0;
    cs = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stub_ready = 1'b0;
      if (!rst || div_annul) active = 0;
      if (active) begin
        cnt--;
        if (cnt == 0) begin
          check("opa_stable", div_opa, ca);
          check("opb_stable", div_opb, cb);
          check("signed_stable", div_signed, cs);
          stub_res   = ref_div(ca, cb, cs);
          stub_ready = 1'b1;
          active     = 0;
        end
      end
      if (div_start && stub_lat > 0) begin
        active = 1;
        cnt    = stub_lat;
        ca     = div_opa;
        cb     = div_opb;
        cs     = div_signed;
      end
    end
  end

  initial begin : monitor
    logic        prev_rv;
    logic [63:0] held, exp;
    prev_rv = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      check("start_annul_exclusive", div_start & div_annul, 0);
      if (rst && result_valid) begin
        if (!prev_rv) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", {63'd0, result_valid}, 0);
          end else begin
            exp = exp_q.pop_front();
            check("result", result_o, exp);
          end
          held = result_o;
        end else begin
          check("result_hold", result_o, held);
        end
      end
      prev_rv = result_valid && rst;
    end
  end

  // Issues one request from IDLE at posedge+1 and returns at posedge+1 of the next IDLE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int lat, input int hold, input int flush_at);
    int cyc, stalls, starts, start_cyc, annuls, annul_cyc, rv_cyc, rv_cnt, hold_left;
    bit fin, tmo;
    req_valid = 1'b1; req_a = a; req_b = b; req_signed = sgn;
    stub_lat = lat; pipe_hold = 1'b0; flush = 1'b0;
    tmo = (b != 0) && (lat <= 0 || lat >= TMO);
    if (flush_at == 0) exp_q.push_back(tmo ? 64'd0 : ref_div(a, b, sgn));
    cyc = 0; stalls = 0; starts = 0; start_cyc = -1; annuls = 0; annul_cyc = -1;
    rv_cyc = -1; rv_cnt = 0; hold_left = hold; fin = 0;
    while (!fin) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (div_start) begin
        starts++;
        start_cyc = cyc;
        check("start_signed", div_signed, sgn);
        check("start_opa", div_opa, a);
        check("start_opb", div_opb, b);
      end
      if (div_annul) begin
        annuls++;
        annul_cyc = cyc;
      end
      if (result_valid) begin
        rv_cnt++;
        if (rv_cyc < 0) rv_cyc = cyc;
        if (hold_left > 0) begin
          pipe_hold = 1'b1;
          hold_left--;
        end else begin
          pipe_hold = 1'b0;
          fin = 1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      flush       = (flush_at > 0 && cyc == flush_at);
      force_ready = flush;
      if (flush) junk_res = {$urandom, $urandom};
      if (flush_at > 0 && cyc == flush_at + 1) req_valid = 1'b0;
      if (flush_at > 0 && cyc > flush_at + 5) fin = 1;
      if (cyc > 400) begin
        check("wait_bound", 64'(cyc), 64'd400);
        fin = 1;
      end
    end
    if (flush_at > 0) begin
      check("flush_no_result", 64'(rv_cyc), -64'sd1);
      check("flush_annul_count", 64'(annuls), 64'd1);
      check("flush_annul_cycle", 64'(annul_cyc), 64'(flush_at + 1));
      check("flush_stalls", 64'(stalls), 64'(flush_at + 1));
      check("flush_starts", 64'(starts), 64'd1);
    end else if (b == 0) begin
      check("dz_latency", 64'(rv_cyc), 64'd1);
      check("dz_starts", 64'(starts), 64'd0);
      check("dz_stalls", 64'(stalls), 64'd1);
      check("dz_annuls", 64'(annuls), 64'd0);
    end else if (tmo) begin
      check("tmo_latency", 64'(rv_cyc), 64'(TMO + 1));
      check("tmo_stalls", 64'(stalls), 64'(TMO + 1));
      check("tmo_annul_count", 64'(annuls), 64'd1);
      check("tmo_annul_cycle", 64'(annul_cyc), 64'(TMO + 1));
      check("tmo_flag", timeout_o, 1);
    end else begin
      check("latency", 64'(rv_cyc), 64'(lat + 2));
      check("stalls", 64'(stalls), 64'(lat + 2));
      check("starts", 64'(starts), 64'd1);
      check("start_cycle", 64'(start_cyc), 64'd1);
      check("annuls", 64'(annuls), 64'd0);
    end
    if (flush_at == 0) check("done_cycles", 64'(rv_cnt), 64'(hold + 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_rvalid"}, result_valid, 0);
    check({tag, "_result"}, result_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_start"}, div_start, 0);
    check({tag, "_annul"}, div_annul, 0);
    check({tag, "_signed"}, div_signed, 0);
    check({tag, "_opa"}, div_opa, 0);
    check({tag, "_opb"}, div_opb, 0);
  endtask

  initial begin : limit
    #500000;
    errors++;
    $display("FAIL global_time_limit: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] a, b;
    logic        sgn;
    int          lat;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'd100, 32'd7, 1'b1, 33, 0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 5, 3, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    run_op(32'hFFFF_FFFF, 32'd16, 1'b0, 10, 0, 0);
    run_op(32'hFFFF_FFFF, 32'd16, 1'b0, 10, 0, 0);
    run_op(32'd5, 32'd0, 1'b1, 1, 0, 0);
    run_op(32'd1234, 32'd5, 1'b0, 40, 0, 10);
    run_op(32'd999, 32'd10, 1'b0, 63, 1, 0);

    // Request squashed by a flush while IDLE must not start anything.
    req_valid = 1'b1; req_b = 32'd3; flush = 1'b1;
    @(negedge clk);
    check("idle_flush_stall", stall_o, 0);
    @(posedge clk);
    #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("idle_flush_start", div_start, 0);
    check("idle_flush_rvalid", result_valid, 0);

    // Stray divider ready while IDLE is ignored.
    @(posedge clk);
    #1;
    junk_ready = 1'b1; junk_res = {$urandom, $urandom};
    @(posedge clk);
    #1;
    junk_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stray_ready_rvalid", result_valid, 0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      else if ($urandom_range(0, 1) == 1) b = $urandom;
      else b = $urandom_range(1, 20);
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      lat = ($urandom_range(0, 5) == 0) ? 63 : int'($urandom_range(1, 40));
      run_op(a, b, sgn, lat, int'($urandom_range(0, 3)), 0);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end

    run_op(32'd77, 32'd3, 1'b0, -1, 1, 0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("timeout_sticky", timeout_o, 1);

    req_valid = 1'b1; req_a = 32'd9; req_b = 32'd4; req_signed = 1'b0; stub_lat = -1;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd50, 32'd7, 1'b0, 3, 0, 0);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
